// File: rtl/maxpool_row_sched.sv
// Streaming binary (OR) max-pool: folds POOL_SIZE input rows into one pooled row,
// emits it over a valid/ready port, discards trailing rows and pulses done per frame.
//
// state | meaning
// IDLE  | waiting for start; no handshakes
// ACCUM | accepting rows of the current group, OR-ing into acc
// EMIT  | pooled row presented, waiting for out_ready
// DRAIN | accepting and discarding rows that do not fill a whole group
// FIN   | one-cycle done pulse, then back to IDLE
module maxpool_row_sched #(
  parameter int ISIZE_L   = 26,
  parameter int ISIZE_H   = 26,
  parameter int POOL_SIZE = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              in_valid,
  input  logic [ISIZE_L-1:0]                in_row,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [ISIZE_L/POOL_SIZE-1:0]      out_row,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              done
);

  localparam int OL  = ISIZE_L / POOL_SIZE;
  localparam int OH  = ISIZE_H / POOL_SIZE;
  localparam int REM = ISIZE_H % POOL_SIZE;
  localparam int RW  = $clog2(ISIZE_H + 1);
  localparam int GW  = $clog2(OH + 1);
  localparam int PW  = $clog2(POOL_SIZE);

  typedef enum logic [2:0] {IDLE, ACCUM, EMIT, DRAIN, FIN} state_t;

  state_t          state;
  logic [OL-1:0]   acc;
  logic [OL-1:0]   h;
  logic [RW-1:0]   row_cnt;
  logic [GW-1:0]   grp_cnt;
  logic [PW-1:0]   pos;

  // Horizontal reduction; columns beyond OL*POOL_SIZE never reach h.
  always_comb begin
    h = '0;
    for (int c = 0; c < OL; c++) begin
      for (int l = 0; l < POOL_SIZE; l++) begin
        h[c] = h[c] | in_row[c*POOL_SIZE + l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      row_cnt   <= '0;
      grp_cnt   <= '0;
      pos       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            row_cnt  <= '0;
            grp_cnt  <= '0;
            pos      <= '0;
            acc      <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc     <= acc | h;
            row_cnt <= row_cnt + RW'(1);
            if (pos == PW'(POOL_SIZE - 1)) begin
              pos       <= '0;
              out_row   <= acc | h;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= EMIT;
            end else begin
              pos <= pos + PW'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            grp_cnt   <= grp_cnt + GW'(1);
            if ((int'(grp_cnt) + 1) < OH) begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end else if (REM != 0) begin
              state    <= DRAIN;
              in_ready <= 1'b1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (in_valid) begin
            row_cnt <= row_cnt + RW'(1);
            if (row_cnt == RW'(ISIZE_H - 1)) begin
              state    <= FIN;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_row_sched.sv
// Scoreboard bench for maxpool_row_sched: default 26x26/P=2 instance plus a 5x5/P=2
// instance for the trailing-row and ignored-column cases.
module tb_maxpool_row_sched;
  localparam int L = 26, H = 26, P = 2, OL = L / P, OH = H / P;

  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [L-1:0] in_row = '0;
  logic in_ready, out_valid, busy, done;
  logic [OL-1:0] out_row;

  logic s_start = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic [4:0] s_in_row = '0;
  logic s_in_ready, s_out_valid, s_busy, s_done;
  logic [1:0] s_out_row;

  always #5 clk = ~clk;

  maxpool_row_sched #(.ISIZE_L(L), .ISIZE_H(H), .POOL_SIZE(P)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_row(in_row),
    .in_ready(in_ready), .out_valid(out_valid), .out_row(out_row),
    .out_ready(out_ready), .busy(busy), .done(done));

  maxpool_row_sched #(.ISIZE_L(5), .ISIZE_H(5), .POOL_SIZE(2)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_row(s_in_row),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_row(s_out_row),
    .out_ready(s_out_ready), .busy(s_busy), .done(s_done));

  int total = 0, bad = 0;
  logic [OL-1:0] exp_q[$];
  logic [1:0]    s_exp_q[$];
  int done_cnt = 0, acc_rows = 0, s_done_cnt = 0, s_acc_rows = 0;
  int bp_mode = 0, hold_cnt = 0, cyc = 0, done_cyc = 0;
  logic prev_hold = 1'b0, prev_done = 1'b0;
  logic [OL-1:0] prev_row, mon_e;
  logic [1:0] s_e;

  task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = always ready, 1 = random, 2 = hold off 5 cycles per row.
  always begin
    @(posedge clk); #1;
    case (bp_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (out_valid) begin
          if (hold_cnt < 5) begin out_ready = 1'b0; hold_cnt++; end
          else out_ready = 1'b1;
        end else begin
          out_ready = 1'b0; hold_cnt = 0;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (out_valid) chk(!in_ready, "ready_during_emit", in_ready, 0);
      if (prev_hold) chk(out_valid && out_row == prev_row, "hold_stable", out_row, prev_row);
      prev_hold = out_valid && !out_ready;
      prev_row  = out_row;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_out", out_row, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk(out_row == mon_e, "out_row", out_row, mon_e);
        end
      end
      if (in_valid && in_ready) acc_rows++;
      if (done) begin
        chk(!prev_done, "done_width", 1, 0);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = done;
      if (s_out_valid && s_out_ready) begin
        if (s_exp_q.size() == 0) chk(1'b0, "s_unexpected_out", s_out_row, 0);
        else begin
          s_e = s_exp_q.pop_front();
          chk(s_out_row == s_e, "s_out_row", s_out_row, s_e);
        end
      end
      if (s_in_valid && s_in_ready) s_acc_rows++;
      if (s_done) s_done_cnt++;
    end
  end

  task automatic send_row(input logic [L-1:0] d, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_row   = L'($urandom);
        start    = ($urandom_range(0, 2) == 0);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    in_valid = 1'b1;
    in_row   = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) chk(1'b0, "row_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_row   = L'($urandom);
  endtask

  // Reference: each output bit is the OR of its POOL x POOL window of the image.
  task automatic push_expected(input logic [L-1:0] img[H]);
    logic [OL-1:0] e;
    for (int r = 0; r < OH; r++) begin
      e = '0;
      for (int c = 0; c < OL; c++)
        for (int dr = 0; dr < P; dr++)
          for (int dc = 0; dc < P; dc++)
            if (img[r*P + dr][c*P + dc]) e[c] = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_frame(input int kind, input bit gaps, input int mode);
    logic [L-1:0] img[H];
    int d0, a0, n, cs;
    for (int r = 0; r < H; r++) img[r] = (kind == 0) ? '0 : L'($urandom);
    if (kind == 0) begin
      img[0][0] = 1'b1; img[1][1] = 1'b1; img[25][25] = 1'b1;
    end
    push_expected(img);
    bp_mode = mode;
    d0 = done_cnt; a0 = acc_rows;
    start = 1'b1;
    @(posedge clk); #1;
    cs = cyc;
    start = 1'b0;
    chk(busy && in_ready, "busy_ready_after_start", {busy, in_ready}, 3);
    for (int r = 0; r < H; r++) send_row(img[r], gaps);
    n = 0;
    while (done_cnt == d0 && n < 300) begin @(posedge clk); #1; n++; end
    chk(done_cnt == d0 + 1, "done_pulse", done_cnt - d0, 1);
    chk(!busy, "idle_after_done", busy, 0);
    if (kind == 0 && !gaps && mode == 0)
      chk(done_cyc - cs == 3 * OH, "peak_throughput", done_cyc - cs, 3 * OH);
    repeat (3) @(posedge clk);
    #1;
    chk(done_cnt == d0 + 1 && exp_q.size() == 0, "frame_complete", exp_q.size(), 0);
    chk(acc_rows - a0 == H, "rows_accepted", acc_rows - a0, H);
  endtask

  task automatic s_send(input logic [4:0] d);
    int n;
    s_in_valid = 1'b1;
    s_in_row   = d;
    n = 0;
    @(negedge clk);
    while (!s_in_ready && n < 100) begin @(negedge clk); n++; end
    if (!s_in_ready) chk(1'b0, "s_row_accept_timeout", 0, 1);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
  endtask

  initial begin
    logic [L-1:0] img[H];
    int d0, n;
    logic [4:0] s_rows[5];

    // Reset with random inputs: every output must stay low.
    repeat (4) begin
      start = 1'($urandom); in_valid = 1'($urandom); in_row = L'($urandom);
      @(negedge clk);
      chk({in_ready, out_valid, busy, done} == 4'b0 && out_row == '0, "reset_outputs",
          {in_ready, out_valid, busy, done, out_row}, 0);
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b1;
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk(!in_ready && !out_valid && !busy, "idle_no_start", {in_ready, out_valid, busy}, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    run_frame(0, 1'b0, 0);
    run_frame(1, 1'b0, 2);
    repeat (3) run_frame(1, 1'b1, 1);

    // Abort a frame after 7 rows, then run a fresh one.
    for (int r = 0; r < H; r++) img[r] = L'($urandom);
    push_expected(img);
    bp_mode = 0;
    d0 = done_cnt;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int r = 0; r < 7; r++) send_row(img[r], 1'b0);
    rst = 1'b0;
    #1;
    chk({in_ready, out_valid, busy, done} == 4'b0 && out_row == '0, "midframe_reset",
        {in_ready, out_valid, busy, done, out_row}, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(done_cnt == d0 && !busy, "no_done_after_abort", done_cnt - d0, 0);
    run_frame(1, 1'b1, 1);

    // 5x5 instance: column 4 and row 4 fall outside every window.
    s_rows[0] = 5'b10000; s_rows[1] = 5'b0; s_rows[2] = 5'b0; s_rows[3] = 5'b0;
    s_rows[4] = 5'b11111;
    s_exp_q.push_back(2'b00);
    s_exp_q.push_back(2'b00);
    s_start = 1'b1; @(posedge clk); #1; s_start = 1'b0;
    chk(s_busy && s_in_ready, "s_busy_after_start", {s_busy, s_in_ready}, 3);
    for (int r = 0; r < 4; r++) s_send(s_rows[r]);
    repeat (2) @(posedge clk);
    #1;
    chk(s_done_cnt == 0 && s_busy && s_in_ready && s_exp_q.size() == 0, "s_drain_wait",
        {s_done_cnt[3:0], s_busy, s_in_ready}, 3);
    s_send(s_rows[4]);
    n = 0;
    while (s_done_cnt == 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk(s_done_cnt == 1, "s_done", s_done_cnt, 1);
    chk(!s_busy, "s_idle_after_done", s_busy, 0);
    chk(s_acc_rows == 5, "s_rows_accepted", s_acc_rows, 5);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
